mul_job_sequencer: RTL and testbench

//  Front end for the serial multiplier core (control unit + datapath). Accepts operand

---
 rtl/mul_job_if.sv | 20 ++
 rtl/mul_job_sequencer.sv | 85 ++++++++
 tb/tb_mul_job_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_job_if.sv
// mul_job_if: operand, product and core handshake bundle for mul_job_sequencer
interface mul_job_if #(parameter int W = 8, parameter int DEPTH = 4);
  logic                     in_valid, in_ready;
  logic [W-1:0]             in_x, in_y;
  logic                     out_valid, out_ready;
  logic [2*W-1:0]           out_p;
  logic                     core_start, core_done;
  logic [W-1:0]             core_x, core_y;
  logic [2*W-1:0]           core_p;
  logic                     busy;
  logic [$clog2(DEPTH):0]   jobs_pending;
  modport slave (
    input  in_valid, in_x, in_y, out_ready, core_done, core_p,
    output in_ready, out_valid, out_p, core_start, core_x, core_y, busy, jobs_pending
  );
  modport master (
    output in_valid, in_x, in_y, out_ready, core_done, core_p,
    input  in_ready, out_valid, out_p, core_start, core_x, core_y, busy, jobs_pending
  );
endinterface

// File: rtl/mul_job_sequencer.sv
// mul_job_sequencer: FIFO-buffered job issue to a serial multiplier core with held product output.
// Optional ZERO_BYPASS_EN: jobs with a zero operand skip the core and produce 0 directly.
module mul_job_sequencer #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  mul_job_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [2*W-1:0] mem_q [DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   x_q, y_q, hx, hy;
  logic [2*W-1:0] p_q, p_d;
  logic           ov_q, ov_d;
  logic           push, pop, zb;

  assign {hx, hy}  = mem_q[rd_q];
  // Full is judged on the registered count so a same-cycle pop never frees a push slot.
  assign bus.in_ready     = cnt_q != CW'(DEPTH);
  assign push             = bus.in_valid && bus.in_ready;
  assign pop              = cnt_q != '0 && (state_q == IDLE || (state_q == HOLD && bus.out_ready));
`ifdef ZERO_BYPASS_EN
  assign zb = pop && (hx == '0 || hy == '0);
`else
  assign zb = 1'b0;
`endif
  assign bus.core_start   = state_q == ISSUE;
  assign bus.busy         = state_q != IDLE;
  assign bus.jobs_pending = cnt_q;
  assign bus.out_valid    = ov_q;
  assign bus.out_p        = p_q;
  assign bus.core_x       = x_q;
  assign bus.core_y       = y_q;

  always_comb begin
    state_d = pop ? (zb ? HOLD : ISSUE)
            : state_q == ISSUE ? WAIT
            : state_q == WAIT && bus.core_done ? HOLD
            : state_q == HOLD && bus.out_ready ? IDLE
            : state_q;
    ov_d = (state_q == WAIT && bus.core_done) || zb ? 1'b1
         : state_q == HOLD && bus.out_ready ? 1'b0
         : ov_q;
    p_d  = state_q == WAIT && bus.core_done ? bus.core_p
         : zb ? '0
         : p_q;
  end

  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= {bus.in_x, bus.in_y};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      p_q     <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      ov_q    <= ov_d;
      cnt_q   <= cnt_q + CW'(push) - CW'(pop);
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) begin
        rd_q <= rd_q + AW'(1);
        x_q  <= hx;
        y_q  <= hy;
      end
    end
  end
endmodule

// File: tb/tb_mul_job_sequencer.sv
// tb_mul_job_sequencer: scoreboard bench with a behavioural multiplier core and random/directed jobs.
module tb_mul_job_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_job_if #(.W(8), .DEPTH(4)) bus();
  mul_job_sequencer #(.W(8), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0, checks = 0, cyc = 0;
  int acc_edge = 0, start_edge = 0, starts = 0, or_mode = 0;
  logic [15:0] exp_q [$];
  logic stall = 1'b0;
  logic cm_done = 1'b0, sp_done = 1'b0;
  logic [15:0] cm_p = '0, sp_p = '0;

  assign bus.core_done = cm_done | sp_done;
  assign bus.core_p    = sp_done ? sp_p : cm_p;

  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y);
    bit ok = 0;
    bus.in_valid = 1'b1; bus.in_x = x; bus.in_y = y;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back({8'd0, x} * {8'd0, y});
        acc_edge = cyc + 1;
        ok = 1;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'(ok), 1);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      if (exp_q.size() == 0 && !bus.busy && !bus.out_valid) ok = 1;
      else step(1);
    end
    if (!ok) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string t);
    chk({t, "_in_ready"}, bus.in_ready, 1);
    chk({t, "_out_valid"}, bus.out_valid, 0);
    chk({t, "_out_p"}, bus.out_p, 0);
    chk({t, "_core_start"}, bus.core_start, 0);
    chk({t, "_core_x"}, bus.core_x, 0);
    chk({t, "_core_y"}, bus.core_y, 0);
    chk({t, "_busy"}, bus.busy, 0);
    chk({t, "_jobs_pending"}, bus.jobs_pending, 0);
  endtask

  // Behavioural core: multiplies the operands presented at start, answers after a random delay.
  initial begin
    logic [15:0] px;
    bit abort;
    int lat;
    forever begin
      @(negedge clk);
      if (bus.core_start && !rst) begin
        px = {8'd0, bus.core_x} * {8'd0, bus.core_y};
        lat = $urandom_range(1, 6);
        abort = 0;
        for (int i = 0; (i < lat || stall) && !abort; i++) begin
          @(posedge clk);
          if (rst) abort = 1;
        end
        if (!abort) begin
          #1 cm_done = 1'b1; cm_p = px;
          @(posedge clk);
          #1 cm_done = 1'b0; cm_p = 16'($urandom);
        end
      end
    end
  end

  // Downstream ready: 0 always 1, 1 random, 2 hold each product 10 cycles, 3 always 0.
  initial begin
    int vcnt = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.out_ready) vcnt = 0; else if (bus.out_valid) vcnt++;
      bus.out_ready = or_mode == 0 ? 1'b1
                    : or_mode == 1 ? ($urandom_range(0, 3) != 0)
                    : or_mode == 2 ? (vcnt >= 10)
                    : 1'b0;
    end
  end

  // Monitor: scoreboard pops, hold stability, start/done protocol.
  initial begin
    bit prev_hold = 0, prev_start = 0, in_flight = 0, done_pend = 0;
    logic [15:0] prev_p = '0, done_p = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 0; prev_start = 0; in_flight = 0; done_pend = 0;
      end else begin
        if (done_pend) begin
          chk("done_to_valid", bus.out_valid, 1);
          chk("done_to_out_p", bus.out_p, done_p);
          done_pend = 0;
        end
        if (prev_hold) begin
          chk("hold_valid", bus.out_valid, 1);
          chk("hold_out_p", bus.out_p, prev_p);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_output", exp_q.size(), 1);
          else chk("product", bus.out_p, exp_q.pop_front());
        end
        if (prev_start) chk("start_width", bus.core_start, 0);
        if (bus.core_start) begin
          chk("start_in_flight", 32'(in_flight), 0);
          chk("start_with_valid", bus.out_valid, 0);
          in_flight = 1; starts++; start_edge = cyc + 1;
        end
        if (bus.core_done && in_flight && bus.busy && !bus.core_start && !bus.out_valid) begin
          done_pend = 1; done_p = bus.core_p; in_flight = 0;
        end
        prev_hold  = bus.out_valid && !bus.out_ready;
        prev_p     = bus.out_p;
        prev_start = bus.core_start;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a, s0;
    bit ok;
    logic [7:0] x, y;
    bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0;
    step(3);
    check_reset_vals("reset");
    rst = 1'b0;
    step(2);

    or_mode = 0;
    send(8'd7, 8'd5);
    a = acc_edge;
    drain();
    chk("start_latency", 32'(start_edge - a), 2);

    stall = 1'b1;
    send(8'd1, 8'd2);
    step(3);
    for (int i = 0; i < 4; i++) send(8'(i + 2), 8'd3);
    chk("full_pending", bus.jobs_pending, 4);
    chk("full_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b1; bus.in_x = 8'd9; bus.in_y = 8'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_stall", bus.in_ready, 0);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    send(8'd9, 8'd9);
    drain();

    or_mode = 2;
    send(8'd3, 8'd4);
    send(8'd255, 8'd255);
    send(8'd1, 8'd1);
    drain();
    or_mode = 0;
    step(2);

    sp_p = 16'hBEEF; sp_done = 1'b1;
    step(1);
    sp_done = 1'b0;
    step(2);
    chk("spur_idle_busy", bus.busy, 0);
    chk("spur_idle_valid", bus.out_valid, 0);
    chk("spur_idle_out_p", bus.out_p, 1);
    or_mode = 3;
    send(8'd2, 8'd3);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (bus.out_valid) ok = 1; else step(1);
    end
    chk("hold_reached", 32'(ok), 1);
    sp_p = 16'h1234; sp_done = 1'b1;
    step(1);
    sp_done = 1'b0;
    step(2);
    chk("spur_hold_out_p", bus.out_p, 6);
    chk("spur_hold_valid", bus.out_valid, 1);
    or_mode = 0;
    drain();

    stall = 1'b1;
    send(8'd4, 8'd4);
    step(3);
    send(8'd5, 8'd5);
    send(8'd6, 8'd6);
    step(2);
    chk("wait_busy", bus.busy, 1);
    chk("wait_pending", bus.jobs_pending, 2);
    #2 rst = 1'b1;
    #1 check_reset_vals("async_reset");
    exp_q.delete();
    stall = 1'b0;
    @(posedge clk); #1;
    step(3);
    rst = 1'b0;
    s0 = starts;
    step(10);
    chk("post_reset_starts", 32'(starts - s0), 0);
    chk("post_reset_busy", bus.busy, 0);
    chk("post_reset_pending", bus.jobs_pending, 0);

    s0 = starts;
    send(8'd0, 8'd9);
    drain();
`ifdef ZERO_BYPASS_EN
    chk("zero_job_starts", 32'(starts - s0), 0);
`else
    chk("zero_job_starts", 32'(starts - s0), 1);
`endif

    or_mode = 1;
    for (int i = 0; i < 40; i++) begin
      x = $urandom_range(0, 7) == 0 ? 8'd0 : 8'($urandom);
      y = $urandom_range(0, 7) == 0 ? 8'd0 : 8'($urandom);
      send(x, y);
      step($urandom_range(0, 3));
    end
    or_mode = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
